// File: rtl/cw_pkg.sv
// cw_pkg: shared constants and controller state type for the constant-weight encoder wrapper
package cw_pkg;

    localparam int CW_W      = 16;
    localparam int CW_T      = 9;
    localparam int CW_N_INIT = 65536;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        DRAIN,
        RECOVER
    } ctrl_state_e;

endpackage

// File: rtl/cw_out_fifo.sv
// cw_out_fifo: synchronous FIFO buffering tagged codeword words toward the output stream
module cw_out_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 9
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CNT_W'(DEPTH);
    assign do_pop  = pop_i && !empty_o && !flush_i;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push_i && !flush_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_q];

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

    // Pointer and occupancy tracking with a synchronous flush
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= do_push ? inc(wr_q) : wr_q;
            rd_q  <= do_pop ? inc(rd_q) : rd_q;
            cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/cw_encoder_ctrl.sv
// cw_encoder_ctrl: feeds a message bit-serially into the encoder, collects its codeword words and supervises hangs
module cw_encoder_ctrl
    import cw_pkg::*;
#(
    parameter int MSG_W   = 64,
    parameter int CW_W    = cw_pkg::CW_W,
    parameter int MAX_CW  = cw_pkg::CW_T,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             msg_valid,
    input  logic [MSG_W-1:0] msg_data,
    output logic             msg_ready,
    output logic             enc_rst_b,
    output logic             enc_start,
    output logic             enc_bin_msg,
    output logic             enc_fifoempty,
    input  logic             enc_readfifo,
    input  logic [CW_W-1:0]  enc_cw_word,
    input  logic             enc_ready,
    input  logic             enc_done,
    output logic             cw_valid,
    output logic [CW_W-1:0]  cw_data,
    output logic             cw_last,
    input  logic             cw_ready,
    output logic             busy,
    output logic             pad_used,
    output logic             err_timeout,
    output logic             err_overflow
);

    localparam int BC_W = $clog2(MSG_W + 1);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    ctrl_state_e      state_q;
    logic [MSG_W-1:0] shreg_q;
    logic [BC_W-1:0]  bitcnt_q;
    logic [TO_W-1:0]  to_q;
    logic             msg_ready_q, enc_rst_b_q, enc_start_q, enc_bin_msg_q, rec_q;
    logic             pad_used_q, err_timeout_q, err_overflow_q;
    logic [CW_W-1:0]  stage_q;
    logic             stage_v_q, pend_q;
    logic             run, accept, timeout, pad, cap, push, push_last, pop, orphan_done;
    logic             fifo_full, fifo_empty;
    logic [CW_W:0]    fifo_rdata;

    assign run         = state_q == RUN;
    assign accept      = msg_valid && msg_ready;
    assign timeout     = run && !enc_done && to_q == TO_W'(TIMEOUT - 1);
    assign pad         = bitcnt_q == BC_W'(MSG_W);
    assign cap         = run && enc_ready;
    // The staged word is released by the next ready/done; a ready+done pair leaves a pending last push.
    assign push        = pend_q || (run && stage_v_q && (enc_ready || enc_done));
    assign push_last   = pend_q || (enc_done && !enc_ready);
    assign orphan_done = run && enc_done && !enc_ready && !stage_v_q;
    assign pop         = cw_valid && cw_ready;

    assign msg_ready     = msg_ready_q && fifo_empty && !stage_v_q;
    assign enc_rst_b     = enc_rst_b_q;
    assign enc_start     = enc_start_q;
    assign enc_bin_msg   = enc_bin_msg_q;
    assign enc_fifoempty = !run;
    assign busy          = state_q != IDLE;
    assign pad_used      = pad_used_q;
    assign err_timeout   = err_timeout_q;
    assign err_overflow  = err_overflow_q;
    assign cw_valid      = !fifo_empty;
    assign {cw_last, cw_data} = fifo_empty ? '0 : fifo_rdata;

    // Sequencing: accept, one-cycle start pulse, supervised run, drain, and two-cycle encoder reset on hang
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            msg_ready_q <= 1'b0;
            enc_rst_b_q <= 1'b0;
            enc_start_q <= 1'b0;
            rec_q       <= 1'b0;
            to_q        <= '0;
        end else begin
            enc_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    enc_rst_b_q <= 1'b1;
                    msg_ready_q <= !accept;
                    if (accept) begin
                        state_q     <= START;
                        enc_start_q <= 1'b1;
                    end
                end
                START: begin
                    to_q    <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    to_q <= to_q + 1'b1;
                    if (enc_done) begin
                        state_q <= DRAIN;
                    end else if (timeout) begin
                        state_q     <= RECOVER;
                        enc_rst_b_q <= 1'b0;
                        rec_q       <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (fifo_empty && !stage_v_q && !pend_q) begin
                        state_q     <= IDLE;
                        msg_ready_q <= 1'b1;
                    end
                end
                RECOVER: begin
                    rec_q <= 1'b1;
                    if (rec_q) begin
                        state_q     <= IDLE;
                        enc_rst_b_q <= 1'b1;
                        msg_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Serialiser: load on accept, shift MSB-first on each encoder pop, deliver zeros once the message is used up
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shreg_q       <= '0;
            bitcnt_q      <= '0;
            enc_bin_msg_q <= 1'b0;
            pad_used_q    <= 1'b0;
        end else if (accept) begin
            shreg_q    <= msg_data;
            bitcnt_q   <= '0;
            pad_used_q <= 1'b0;
        end else if (run && enc_readfifo) begin
            enc_bin_msg_q <= pad ? 1'b0 : shreg_q[MSG_W-1];
            shreg_q       <= shreg_q << 1;
            bitcnt_q      <= pad ? bitcnt_q : bitcnt_q + 1'b1;
            pad_used_q    <= pad_used_q || pad;
        end
    end

    // Capture stage and sticky error flags; a timeout discards the staged word along with the FIFO
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stage_q        <= '0;
            stage_v_q      <= 1'b0;
            pend_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            pend_q         <= cap && enc_done;
            stage_q        <= cap ? enc_cw_word : stage_q;
            stage_v_q      <= timeout ? 1'b0 : cap ? 1'b1 : push ? 1'b0 : stage_v_q;
            err_timeout_q  <= !accept && (err_timeout_q || timeout);
            err_overflow_q <= !accept && (err_overflow_q || orphan_done ||
                              (push && fifo_full && !pop && !timeout));
        end
    end

    cw_out_fifo #(
        .WIDTH (CW_W + 1),
        .DEPTH (MAX_CW)
    ) u_fifo (
        .clk     (clk),
        .rst_b   (rst_b),
        .flush_i (timeout),
        .push_i  (push),
        .wdata_i ({push_last, stage_q}),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_cw_encoder_ctrl.sv
// tb_cw_encoder_ctrl: randomized encoder stub and output sink checked against a bit/word stream model
module tb_cw_encoder_ctrl;

    logic        clk = 1'b0, rst_b = 1'b0, msg_valid = 1'b0;
    logic [63:0] msg_data = '0;
    logic        enc_readfifo = 1'b0, enc_ready = 1'b0, enc_done = 1'b0, cw_ready = 1'b0;
    logic [15:0] enc_cw_word = '0;
    logic        msg_ready, enc_rst_b, enc_start, enc_bin_msg, enc_fifoempty;
    logic        cw_valid, cw_last, busy, pad_used, err_timeout, err_overflow;
    logic [15:0] cw_data;

    int          n_cmp = 0, n_bad = 0;
    int          cyc_n = 0, acc_cyc = 0, start_cyc = 0, n_start = 0, n_low = 0, low_cyc = 0;
    int          stall_bad = 0, rdy_mode = 0;
    logic        hold_v = 1'b0, fe_run = 1'b1;
    logic [16:0] hold_d = '0;
    logic        bits[$];
    logic [16:0] got[$];
    logic [15:0] words[$];

    cw_encoder_ctrl dut (
        .clk(clk), .rst_b(rst_b), .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
        .enc_rst_b(enc_rst_b), .enc_start(enc_start), .enc_bin_msg(enc_bin_msg),
        .enc_fifoempty(enc_fifoempty), .enc_readfifo(enc_readfifo), .enc_cw_word(enc_cw_word),
        .enc_ready(enc_ready), .enc_done(enc_done), .cw_valid(cw_valid), .cw_data(cw_data),
        .cw_last(cw_last), .cw_ready(cw_ready), .busy(busy), .pad_used(pad_used),
        .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    // One clock cycle at the falling edge: observe, then drive the stub and sink for the next rising edge.
    task automatic cyc();
        @(negedge clk);
        cyc_n++;
        if (enc_readfifo) bits.push_back(enc_bin_msg);
        if (enc_start) begin n_start++; start_cyc = cyc_n; end
        if (rst_b && !enc_rst_b) begin if (n_low == 0) low_cyc = cyc_n; n_low++; end
        if (hold_v && (!cw_valid || {cw_last, cw_data} !== hold_d)) stall_bad++;
        enc_readfifo = 1'b0; enc_ready = 1'b0; enc_done = 1'b0;
        cw_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (cyc_n % 4 == 0) : 1'b0;
        if (cw_valid && cw_ready) got.push_back({cw_last, cw_data});
        hold_v = cw_valid && !cw_ready;
        hold_d = {cw_last, cw_data};
    endtask

    task automatic send(input logic [63:0] m);
        int k = 0;
        n_start = 0;
        while (!msg_ready && k < 500) begin cyc(); k++; end
        n_cmp++;
        if (msg_ready !== 1'b1) begin n_bad++; $display("FAIL accept_wait: msg_ready=%b required 1", msg_ready); end
        msg_valid = 1'b1; msg_data = m; acc_cyc = cyc_n;
        cyc();
        msg_valid = 1'b0;
    endtask

    // Encoder stub: pop npops bits, emit every queued word, then signal done (optionally with the last word).
    task automatic do_block(input logic [63:0] m, input int npops, input bit merge);
        int k = 0;
        bits.delete(); got.delete(); stall_bad = 0;
        send(m);
        cyc();
        fe_run = enc_fifoempty;
        for (int i = 0; i < npops; i++) begin enc_readfifo = 1'b1; cyc(); end
        for (int j = 0; j < words.size(); j++) begin
            enc_ready = 1'b1; enc_cw_word = words[j];
            if (merge && j == words.size() - 1) enc_done = 1'b1;
            cyc();
            if ($urandom_range(0, 2) == 0) cyc();
        end
        if (!merge) begin enc_done = 1'b1; cyc(); end
        if (rdy_mode == 2) rdy_mode = 0;
        while (!(msg_ready && !busy) && k < 400) begin cyc(); k++; end
    endtask

    // Reference: bit i of the serial stream is message bit 63-i, and zero once the message is exhausted.
    function automatic int bit_errs(input logic [63:0] m, input int n);
        int e = bits.size() != n;
        for (int i = 0; i < n && i < bits.size(); i++)
            if (bits[i] !== (i < 64 ? m[63-i] : 1'b0)) e++;
        return e;
    endfunction

    // Reference: the first nexp emitted words in order, last tag only on the final one when requested.
    function automatic int beat_errs(input int nexp, input bit with_last);
        int e = got.size() != nexp;
        for (int i = 0; i < nexp && i < got.size(); i++)
            if (got[i] !== {with_last && i == nexp - 1, words[i]}) e++;
        return e;
    endfunction

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if ({msg_ready, enc_rst_b, enc_start, enc_bin_msg, enc_fifoempty, cw_valid, cw_last, busy,
             pad_used, err_timeout, err_overflow} !== 11'b00001000000 || cw_data !== 16'h0) begin
            n_bad++; $display("FAIL reset_values: got %b/%h required 00001000000/0000",
                {msg_ready, enc_rst_b, enc_start, enc_bin_msg, enc_fifoempty, cw_valid, cw_last, busy,
                 pad_used, err_timeout, err_overflow}, cw_data);
        end
        rst_b = 1'b1;
        cyc();
        n_cmp++;
        if ({msg_ready, enc_rst_b, busy} !== 3'b110) begin
            n_bad++; $display("FAIL reset_release: msg_ready/enc_rst_b/busy=%b required 110", {msg_ready, enc_rst_b, busy});
        end
    endtask

    task automatic test_pattern();
        logic [63:0] m = 64'h8000_0000_0000_0001;
        rdy_mode = 0; rand_words(9);
        do_block(m, 64, 1'b0);
        n_cmp++; if (bit_errs(m, 64) != 0) begin n_bad++; $display("FAIL p1_bits: %0d bit errors, required 0", bit_errs(m, 64)); end
        n_cmp++; if (pad_used !== 1'b0) begin n_bad++; $display("FAIL p1_pad: pad_used=%b required 0", pad_used); end
        n_cmp++; if (n_start != 1 || start_cyc != acc_cyc + 1) begin
            n_bad++; $display("FAIL p1_start: %0d pulses at offset %0d, required 1 at offset 1", n_start, start_cyc - acc_cyc); end
        n_cmp++; if (fe_run !== 1'b0) begin n_bad++; $display("FAIL p1_fifoempty: enc_fifoempty=%b in RUN required 0", fe_run); end
        n_cmp++; if (beat_errs(9, 1'b1) != 0) begin n_bad++; $display("FAIL p1_words: %0d word errors of %0d beats, required 0", beat_errs(9, 1'b1), got.size()); end
    endtask

    task automatic test_stream(input int mode, input string tag);
        words.delete();
        for (int j = 1; j <= 9; j++) words.push_back(16'(j));
        rdy_mode = mode;
        do_block({$urandom, $urandom}, 64, 1'b0);
        n_cmp++; if (beat_errs(9, 1'b1) != 0) begin n_bad++; $display("FAIL %s_words: %0d word errors of %0d beats, required 0", tag, beat_errs(9, 1'b1), got.size()); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL %s_stable: %0d stall changes, required 0", tag, stall_bad); end
        n_cmp++; if ({msg_ready, busy, err_overflow} !== 3'b100) begin
            n_bad++; $display("FAIL %s_idle: msg_ready/busy/err_overflow=%b required 100", tag, {msg_ready, busy, err_overflow}); end
        rdy_mode = 0;
    endtask

    task automatic test_padding();
        logic [63:0] m = {$urandom, $urandom};
        rdy_mode = 0; rand_words(3);
        do_block(m, 70, 1'b1);
        n_cmp++; if (bit_errs(m, 70) != 0) begin n_bad++; $display("FAIL pad_bits: %0d bit errors, required 0", bit_errs(m, 70)); end
        n_cmp++; if (bits.size() != 70 || {bits[64], bits[65], bits[66], bits[67], bits[68], bits[69]} !== 6'b0) begin
            n_bad++; $display("FAIL pad_tail: %0d bits, tail not all zero, required 70 with 6 zeros", bits.size()); end
        n_cmp++; if (pad_used !== 1'b1) begin n_bad++; $display("FAIL pad_flag: pad_used=%b required 1", pad_used); end
        n_cmp++; if (beat_errs(3, 1'b1) != 0) begin n_bad++; $display("FAIL pad_words: %0d word errors, required 0", beat_errs(3, 1'b1)); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [63:0] m = {$urandom, $urandom};
            int np = $urandom_range(40, 72);
            int nw = $urandom_range(1, 9);
            bit mg = 1'($urandom_range(0, 1));
            rdy_mode = $urandom_range(0, 1);
            rand_words(nw);
            do_block(m, np, mg);
            n_cmp++; if (bit_errs(m, np) != 0) begin n_bad++; $display("FAIL rnd%0d_bits: %0d bit errors, required 0", it, bit_errs(m, np)); end
            n_cmp++; if (beat_errs(nw, 1'b1) != 0 || stall_bad != 0) begin
                n_bad++; $display("FAIL rnd%0d_words: %0d word errors, %0d stall changes, required 0/0", it, beat_errs(nw, 1'b1), stall_bad); end
            n_cmp++; if ({pad_used, err_overflow, err_timeout} !== {np > 64, 2'b00}) begin
                n_bad++; $display("FAIL rnd%0d_flags: pad/ovf/to=%b required %b", it, {pad_used, err_overflow, err_timeout}, {np > 64, 2'b00}); end
        end
        rdy_mode = 0;
    endtask

    task automatic test_overflow();
        rdy_mode = 2; rand_words(11);
        do_block({$urandom, $urandom}, 0, 1'b0);
        n_cmp++; if (beat_errs(9, 1'b0) != 0) begin n_bad++; $display("FAIL ovf_words: %0d word errors of %0d beats, required 0", beat_errs(9, 1'b0), got.size()); end
        n_cmp++; if ({err_overflow, msg_ready} !== 2'b11) begin n_bad++; $display("FAIL ovf_flag: err_overflow/msg_ready=%b required 11", {err_overflow, msg_ready}); end
    endtask

    task automatic test_timeout();
        int k = 0;
        got.delete();
        send({$urandom, $urandom});
        cyc();
        rdy_mode = 2;
        for (int j = 0; j < 3; j++) begin enc_ready = 1'b1; enc_cw_word = 16'($urandom); cyc(); end
        n_low = 0;
        while (!(n_low > 0 && msg_ready) && k < 4300) begin cyc(); k++; end
        n_cmp++; if (low_cyc - (acc_cyc + 2) != 4096) begin n_bad++; $display("FAIL to_cycles: %0d RUN cycles before recovery, required 4096", low_cyc - acc_cyc - 2); end
        n_cmp++; if (n_low != 2) begin n_bad++; $display("FAIL to_rst: enc_rst_b low %0d cycles, required 2", n_low); end
        n_cmp++; if ({err_timeout, cw_valid, msg_ready, busy} !== 4'b1010) begin
            n_bad++; $display("FAIL to_state: err_timeout/cw_valid/msg_ready/busy=%b required 1010", {err_timeout, cw_valid, msg_ready, busy}); end
        rdy_mode = 0;
        repeat (4) cyc();
        n_cmp++; if (got.size() != 0) begin n_bad++; $display("FAIL to_flush: %0d beats after flush, required 0", got.size()); end
    endtask

    task automatic test_midrun_reset();
        got.delete();
        send({$urandom, $urandom});
        cyc();
        rdy_mode = 2;
        for (int j = 0; j < 4; j++) begin enc_ready = 1'b1; enc_cw_word = 16'($urandom); cyc(); end
        cyc();
        n_cmp++; if (cw_valid !== 1'b1) begin n_bad++; $display("FAIL mr_pre: cw_valid=%b before reset, required 1", cw_valid); end
        rst_b = 1'b0; hold_v = 1'b0; rdy_mode = 0;
        #1;
        n_cmp++;
        if ({msg_ready, enc_rst_b, enc_start, enc_bin_msg, enc_fifoempty, cw_valid, cw_last, busy,
             pad_used, err_timeout, err_overflow} !== 11'b00001000000 || cw_data !== 16'h0) begin
            n_bad++; $display("FAIL mr_reset: got %b/%h required 00001000000/0000",
                {msg_ready, enc_rst_b, enc_start, enc_bin_msg, enc_fifoempty, cw_valid, cw_last, busy,
                 pad_used, err_timeout, err_overflow}, cw_data);
        end
        repeat (2) cyc();
        rst_b = 1'b1;
        got.delete();
        repeat (5) cyc();
        n_cmp++; if (got.size() != 0 || enc_rst_b !== 1'b1) begin
            n_bad++; $display("FAIL mr_quiet: %0d beats, enc_rst_b=%b, required 0 and 1", got.size(), enc_rst_b); end
        rand_words(9);
        do_block(64'hDEAD_BEEF_0123_4567, 64, 1'b1);
        n_cmp++; if (beat_errs(9, 1'b1) != 0 || bit_errs(64'hDEAD_BEEF_0123_4567, 64) != 0) begin
            n_bad++; $display("FAIL mr_after: %0d word errors, %0d bit errors, required 0/0",
                beat_errs(9, 1'b1), bit_errs(64'hDEAD_BEEF_0123_4567, 64)); end
    endtask

    initial begin
        test_reset();
        test_pattern();
        test_stream(0, "s2");
        test_stream(1, "s3");
        test_padding();
        test_random();
        test_overflow();
        test_timeout();
        test_midrun_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cw_encoder_ctrl.md
# cw_encoder_ctrl

Sequencer wrapped around the constant-weight `encoder_main` datapath. It accepts one packed binary message per handshake and serialises it MSB-first into the encoder's FIFO-style bit interface. It starts and supervises the encoder, captures every codeword word the encoder emits and presents them downstream with a valid/ready stream and a last marker. It also recovers the encoder on a hang by timeout.

## Interface
Parameters:
- `MSG_W`, 64: message bits per block.
- `CW_W`, 16: codeword word width; matches encoder `cw_word`.
- `MAX_CW`, 9: output FIFO depth; equals encoder weight t.
- `TIMEOUT`, 4096: maximum RUN cycles before abort.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_b` in 1: reset is asynchronous and active-low.
- `msg_valid` in 1, `msg_data` in MSG_W, `msg_ready` out 1: message input handshake.
- `enc_rst_b` out 1: encoder reset, active-low.
- `enc_start` out 1: encoder start pulse.
- `enc_bin_msg` out 1: current message bit.
- `enc_fifoempty` out 1: bit source empty.
- `enc_readfifo` in 1: encoder bit pop.
- `enc_cw_word` in CW_W, `enc_ready` in 1, `enc_done` in 1: encoder results.
- `cw_valid` out 1, `cw_data` out CW_W, `cw_last` out 1, `cw_ready` in 1: output stream.
- `busy` out 1: state ≠ IDLE.
- `pad_used` out 1: sticky; zero padding was popped.
- `err_timeout` out 1: sticky.
- `err_overflow` out 1: sticky.

## Operation
States: IDLE, START, RUN, DRAIN, RECOVER.
- **IDLE:** `msg_ready`=1 only when the output FIFO is empty and the stage is empty. On `msg_valid&msg_ready`:
  - load the shift register with `msg_data`; set bitcnt=0.
  - clear all sticky flags.
  - go to START.
- **START:** `enc_start`=1 for exactly one cycle, then go to RUN.
- **RUN:** `enc_fifoempty`=0.
  - Each cycle with `enc_readfifo`=1, at the next edge `enc_bin_msg` ← shreg MSB, shreg shifts left, and bitcnt increments (saturates at MSG_W).
  - Pops with bitcnt==MSG_W deliver 0 and set `pad_used`.
  - On `enc_done`, go to DRAIN.
  - If the RUN cycle counter reaches TIMEOUT, set `err_timeout`, flush the FIFO and stage, and go to RECOVER.
- **RECOVER:** `enc_rst_b`=0 for 2 cycles, then go to IDLE.
- **DRAIN:** go to IDLE when the FIFO is empty after the `cw_last` beat is accepted.
- Outside RUN: `enc_fifoempty`=1 and `enc_readfifo` is ignored.

Capture path:
- On `enc_ready`=1, `enc_cw_word` is written to a one-entry stage.
- The stage is pushed to the FIFO, tagged `last`=`enc_done`, on the next `enc_ready` or on `enc_done`.
- If `enc_ready` and `enc_done` arrive in the same cycle, push the old stage with last=0, then push the new word with last=1 next cycle.
- Push to a full FIFO: drop the word and set `err_overflow`.
- `enc_done` with the stage empty: push nothing; the previous FIFO tail is not retro-tagged; set `err_overflow`.

Output: standard valid/ready; `cw_data` and `cw_last` are held stable while `cw_valid&!cw_ready`.

## Timing
Reset values:
- `msg_ready`=0 during reset and 1 in the first IDLE cycle after reset.
- `enc_rst_b`=0 while `rst_b`=0 and 1 the cycle after release.
- `enc_start`=0, `enc_bin_msg`=0, `enc_fifoempty`=1.
- `cw_valid`=0, `cw_data`=0, `cw_last`=0, `busy`=0, all sticky flags 0.

Latencies:
- `enc_start` is asserted the cycle after message accept.
- A bit is visible on `enc_bin_msg` one cycle after the pop cycle; this matches encoder sampling at its cnt==1.
- Captured word to `cw_valid`: at most 2 cycles after the following `enc_ready`/`enc_done`.
- FIFO has simultaneous push/pop when full: pop first, push succeeds.

Other rules:
- The encoder cannot stall, so the FIFO must absorb all MAX_CW words with no backpressure.
- An `rst_b` assertion mid-RUN aborts immediately: all state returns to reset values and the FIFO is emptied.
- Counter widths: bitcnt uses $clog2(MSG_W+1) bits; the timeout counter uses $clog2(TIMEOUT+1) bits.

## Structure
- Package `cw_pkg`: `CW_W`, `CW_T`=9, `CW_N_INIT`=65536, and the ctrl state enum.
- Sub-module `cw_out_fifo`, a synchronous FIFO with parameters WIDTH=CW_W+1 and DEPTH=MAX_CW, providing full/empty flags.
- Controller FSM, serialiser, stage and timeout counter all live in `cw_encoder_ctrl`.

## Test plan
1. `msg_data`=64'h8000_0000_0000_0001; encoder stub pops 64 bits.
   - Required: observed bit stream is 1, then 62 zeros, then 1.
   - `pad_used`=0; `enc_start` is high exactly 1 cycle, the cycle after accept.
2. Stub emits 9 ready pulses with words 0x0001..0x0009, then done.
   - Required: stream carries 0x0001..0x0009, with `cw_last` only on 0x0009.
   - `cw_ready` tied 1; `msg_ready` returns to 1 after the last beat.
3. Same as scenario 2, with `cw_ready` toggling 1 cycle on / 3 off.
   - Required: no word is lost or duplicated; data holds stable while stalled.
4. Stub pops 70 bits.
   - Required: the last 6 bits delivered are 0; `pad_used`=1.
5. Stub never asserts `enc_done`.
   - Required: after 4096 RUN cycles, `err_timeout`=1 and `enc_rst_b` is low for 2 cycles.
   - FIFO is empty; IDLE with `msg_ready`=1 follows.
6. `rst_b` pulses low mid-RUN after 3 words are captured.
   - Required: all outputs are at reset values and `cw_valid` stays 0.
   - A new message then completes normally.
